// File: rtl/pcpi_muldiv_iter.sv
// Iterative PCPI M-extension unit: MUL/MULH/MULHSU/MULHU and optional DIV/DIVU/REM/REMU.
// Latency XLEN/MUL_STEPS+1 (multiply) or XLEN+1 (divide) edges; dropping pcpi_valid in RUN abandons the op.
module pcpi_muldiv_iter #(
  parameter int XLEN       = 32,
  parameter int MUL_STEPS  = 1,
  parameter bit ENABLE_DIV = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_STEPS - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_HOLD
  } state_t;

  state_t state, state_nx;

  logic [2:0]        funct3;
  logic              is_m;
  logic              match;
  logic              accept;
  logic              unused_insn;

  logic              a_sgn, b_sgn;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;

  logic [2:0]        op;
  logic              op_div;
  logic [CW-1:0]     cnt;
  logic              last;

  logic [2*XLEN-1:0] acc, acc_nx;
  logic [2*XLEN-1:0] ma;
  logic [XLEN-1:0]   mb;
  logic              mb_sgn;

  logic [XLEN-1:0]   quo, quo_nx;
  logic [XLEN-1:0]   rem, rem_nx;
  logic [XLEN-1:0]   dvs;
  logic              q_neg, r_neg;
  logic [XLEN:0]     div_sh;
  logic [XLEN+1:0]   div_trial;

  logic [XLEN-1:0]   result;

  assign funct3      = pcpi_insn[14:12];
  assign is_m        = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
  assign match       = is_m && (!funct3[2] || ENABLE_DIV);
  assign accept      = (state == S_IDLE) && pcpi_valid && match;
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // Operand signedness by funct3: MULH s*s, MULHSU s*u, DIV/REM signed.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (funct3)
      3'd1, 3'd4, 3'd6: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'd2:    a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = a_sgn && pcpi_rs1[XLEN-1];
  assign b_neg = b_sgn && pcpi_rs2[XLEN-1];
  assign a_mag = a_neg ? -pcpi_rs1 : pcpi_rs1;
  assign b_mag = b_neg ? -pcpi_rs2 : pcpi_rs2;

  assign last = op_div ? (cnt == DIV_LAST) : (cnt == MUL_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (pcpi_valid && match) state_nx = S_RUN;
      S_RUN: begin
        if (!pcpi_valid) begin
          state_nx = S_IDLE;
        end else if (last) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_HOLD;
      S_HOLD:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // The top multiplier bit of a signed rs2 carries weight -2^(XLEN-1), so it subtracts.
  always_comb begin
    acc_nx = acc;
    for (int j = 0; j < MUL_STEPS; j++) begin
      if (mb[j]) begin
        if (mb_sgn && (cnt == MUL_LAST) && (j == MUL_STEPS - 1)) begin
          acc_nx = acc_nx - (ma << j);
        end else begin
          acc_nx = acc_nx + (ma << j);
        end
      end
    end
  end

  // Restoring step: quo shifts the dividend out while quotient bits shift in.
  always_comb begin
    div_sh    = {rem, quo[XLEN-1]};
    div_trial = {1'b0, div_sh} - {2'b00, dvs};
    if (!div_trial[XLEN+1]) begin
      rem_nx = div_trial[XLEN-1:0];
      quo_nx = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_nx = div_sh[XLEN-1:0];
      quo_nx = {quo[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    result = '0;
    case (op)
      3'd0:             result = acc[XLEN-1:0];
      3'd1, 3'd2, 3'd3: result = acc[2*XLEN-1:XLEN];
      3'd4, 3'd5:       result = q_neg ? -quo : quo;
      default:          result = r_neg ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op         <= '0;
      op_div     <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      ma         <= '0;
      mb         <= '0;
      mb_sgn     <= 1'b0;
      quo        <= '0;
      rem        <= '0;
      dvs        <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      pcpi_rd    <= '0;
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
    end else begin
      if (accept) begin
        op     <= funct3;
        op_div <= funct3[2];
        cnt    <= '0;
        acc    <= '0;
        ma     <= {{XLEN{a_neg}}, pcpi_rs1};
        mb     <= pcpi_rs2;
        mb_sgn <= b_sgn && !funct3[2];
        quo    <= a_mag;
        rem    <= '0;
        dvs    <= b_mag;
        // A zero divisor yields all-ones quotient regardless of dividend sign.
        q_neg  <= (a_neg ^ b_neg) && (pcpi_rs2 != '0);
        r_neg  <= a_neg;
      end else if (state == S_RUN) begin
        cnt <= cnt + 1'b1;
        if (op_div) begin
          quo <= quo_nx;
          rem <= rem_nx;
        end else begin
          acc <= acc_nx;
          ma  <= ma << MUL_STEPS;
          mb  <= mb >> MUL_STEPS;
        end
      end

      if (state == S_DONE) begin
        pcpi_rd <= result;
      end
      pcpi_wait  <= (state_nx == S_RUN) || (state_nx == S_DONE);
      pcpi_ready <= (state == S_DONE);
      pcpi_wr    <= (state == S_DONE);
    end
  end

endmodule
